// File: rtl/request_tick_timer.sv
// rtl/request_tick_timer.sv - request-triggered tick sequencer (burst or continuous)
module request_tick_timer #(
    parameter int CLK_FREQ = 50000000,
    parameter int TICK_HZ  = 1,
    parameter int N_REQ    = 3,
    parameter int BURST_W  = 4
) (
    input  logic               clk_50,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic               mode,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               cancel,
    output logic               tick,
    output logic               phase,
    output logic               busy,
    output logic [N_REQ-1:0]   req_seen,
    output logic [BURST_W-1:0] tick_count
);
    localparam int PERIOD = CLK_FREQ / TICK_HZ;
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    if (PERIOD < 2) begin : g_bad_period
        $error("request_tick_timer: CLK_FREQ/TICK_HZ must be at least 2");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BURST_W-1:0]   remaining_q;
    logic                 mode_q;
    logic [N_REQ-1:0]     req_prev_q;
    logic                 tick_q;
    logic                 phase_q;
    logic                 busy_q;
    logic [N_REQ-1:0]     req_seen_q;
    logic [BURST_W-1:0]   tick_count_q;

    logic [N_REQ-1:0]     req_edge;
    logic                 trig;
    logic [BURST_W-1:0]   reload;

    assign req_edge = req & ~req_prev_q;
    assign trig     = |req_edge;
    assign reload   = (burst_len == '0) ? BURST_W'(1) : burst_len;

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            remaining_q  <= '0;
            mode_q       <= 1'b0;
            req_prev_q   <= '1;
            tick_q       <= 1'b0;
            phase_q      <= 1'b0;
            busy_q       <= 1'b0;
            req_seen_q   <= '0;
            tick_count_q <= '0;
        end else begin
            req_prev_q <= req;
            tick_q     <= 1'b0;
            if (cancel) begin
                state_q      <= IDLE;
                cnt_q        <= '0;
                busy_q       <= 1'b0;
                req_seen_q   <= '0;
                tick_count_q <= '0;
            end else if (state_q == IDLE) begin
                if (trig) begin
                    state_q      <= RUN;
                    cnt_q        <= '0;
                    remaining_q  <= reload;
                    mode_q       <= mode;
                    req_seen_q   <= req_edge;
                    tick_count_q <= '0;
                    busy_q       <= 1'b1;
                end
            end else begin
                if (cnt_q == CNT_LAST) begin
                    cnt_q   <= '0;
                    tick_q  <= 1'b1;
                    phase_q <= ~phase_q;
                    if (tick_count_q != '1) begin
                        tick_count_q <= tick_count_q + BURST_W'(1);
                    end
                    if (!mode_q) begin
                        remaining_q <= remaining_q - BURST_W'(1);
                        if (remaining_q == BURST_W'(1)) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                // A retrigger overrides the end-of-burst decision taken above.
                if (trig) begin
                    state_q     <= RUN;
                    busy_q      <= 1'b1;
                    cnt_q       <= '0;
                    remaining_q <= reload;
                    mode_q      <= mode;
                    req_seen_q  <= req_seen_q | req_edge;
                end
            end
        end
    end

    assign tick       = tick_q;
    assign phase      = phase_q;
    assign busy       = busy_q;
    assign req_seen   = req_seen_q;
    assign tick_count = tick_count_q;
endmodule

// File: tb/tb_request_tick_timer.sv
// tb/tb_request_tick_timer.sv - directed self-checking bench for request_tick_timer
module tb_request_tick_timer;
    logic       clk_50 = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic       mode;
    logic [3:0] burst_len;
    logic       cancel;
    logic       tick;
    logic       phase;
    logic       busy;
    logic [2:0] req_seen;
    logic [3:0] tick_count;

    int n_checks = 0;
    int n_errors = 0;

    request_tick_timer #(
        .CLK_FREQ(10),
        .TICK_HZ (1),
        .N_REQ   (3),
        .BURST_W (4)
    ) dut (
        .clk_50    (clk_50),
        .rst_n     (rst_n),
        .req       (req),
        .mode      (mode),
        .burst_len (burst_len),
        .cancel    (cancel),
        .tick      (tick),
        .phase     (phase),
        .busy      (busy),
        .req_seen  (req_seen),
        .tick_count(tick_count)
    );

    always #5 clk_50 = ~clk_50;

    task automatic step(input int n);
        for (int s = 0; s < n; s++) begin
            @(posedge clk_50);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 3'b001; mode = 1'b0; burst_len = 4'd3; cancel = 1'b0;
        step(2);
        check("rst_busy", 32'(busy), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_phase", 32'(phase), 0);
        check("rst_req_seen", 32'(req_seen), 0);
        check("rst_tick_count", 32'(tick_count), 0);

        // Held request through reset must not trigger.
        rst_n = 1'b1;
        step(3);
        check("held_no_trigger", 32'(busy), 0);

        // Burst of 3 on req[0].
        req = 3'b000; step(1);
        req = 3'b001; step(1);
        check("b3_busy", 32'(busy), 1);
        check("b3_req_seen", 32'(req_seen), 32'h1);
        for (int i = 1; i <= 30; i++) begin
            step(1);
            check($sformatf("b3_tick_%0d", i), 32'(tick), 32'(i % 10 == 0));
            check($sformatf("b3_busy_%0d", i), 32'(busy), 32'(i < 30));
        end
        check("b3_tick_count", 32'(tick_count), 3);
        check("b3_phase", 32'(phase), 1);
        step(1);
        check("b3_tick_after", 32'(tick), 0);

        // burst_len=0 behaves as 1, trigger on req[2].
        burst_len = 4'd0; req = 3'b100; step(1);
        check("b0_busy", 32'(busy), 1);
        check("b0_req_seen", 32'(req_seen), 32'h4);
        check("b0_tick_count0", 32'(tick_count), 0);
        for (int i = 1; i <= 25; i++) begin
            step(1);
            check($sformatf("b0_tick_%0d", i), 32'(tick), 32'(i == 10));
            check($sformatf("b0_busy_%0d", i), 32'(busy), 32'(i < 10));
        end
        check("b0_tick_count", 32'(tick_count), 1);
        check("b0_phase", 32'(phase), 0);

        // Continuous mode, 20 ticks, saturation, then cancel at cnt=9.
        mode = 1'b1; req = 3'b000; step(1);
        req = 3'b010; step(1);
        check("cont_busy", 32'(busy), 1);
        check("cont_req_seen", 32'(req_seen), 32'h2);
        for (int i = 1; i <= 200; i++) begin
            step(1);
            check($sformatf("cont_tick_%0d", i), 32'(tick), 32'(i % 10 == 0));
        end
        check("cont_sat", 32'(tick_count), 15);
        check("cont_phase", 32'(phase), 0);
        step(9);
        cancel = 1'b1; step(1);
        cancel = 1'b0;
        check("cancel_tick", 32'(tick), 0);
        check("cancel_busy", 32'(busy), 0);
        check("cancel_tick_count", 32'(tick_count), 0);
        check("cancel_req_seen", 32'(req_seen), 0);
        check("cancel_phase", 32'(phase), 0);
        for (int i = 1; i <= 12; i++) begin
            step(1);
            check($sformatf("cancel_idle_tick_%0d", i), 32'(tick), 0);
        end

        // Cancel in IDLE suppresses a coincident trigger.
        req = 3'b000; step(1);
        req = 3'b001; cancel = 1'b1; step(1);
        cancel = 1'b0;
        check("cancel_idle_suppress", 32'(busy), 0);
        step(1);
        check("cancel_idle_no_late", 32'(busy), 0);

        // Burst of 2, retrigger via req[1] five cycles in.
        mode = 1'b0; burst_len = 4'd2;
        req = 3'b000; step(1);
        req = 3'b001; step(1);
        check("rt_busy", 32'(busy), 1);
        step(4);
        req = 3'b011; step(1);
        check("rt_req_seen", 32'(req_seen), 32'h3);
        check("rt_tick0", 32'(tick), 0);
        for (int i = 1; i <= 20; i++) begin
            step(1);
            check($sformatf("rt_tick_%0d", i), 32'(tick), 32'(i % 10 == 0));
            check($sformatf("rt_busy_%0d", i), 32'(busy), 32'(i < 20));
        end
        check("rt_tick_count", 32'(tick_count), 2);

        // Retrigger coinciding with the final burst tick.
        burst_len = 4'd1;
        req = 3'b000; step(1);
        req = 3'b001; step(1);
        check("term_busy", 32'(busy), 1);
        step(9);
        req = 3'b011; step(1);
        check("term_tick", 32'(tick), 1);
        check("term_busy_stays", 32'(busy), 1);
        check("term_req_seen", 32'(req_seen), 32'h3);
        check("term_phase", 32'(phase), 1);
        for (int i = 1; i <= 10; i++) begin
            step(1);
            check($sformatf("term_tick_%0d", i), 32'(tick), 32'(i == 10));
            check($sformatf("term_busy_%0d", i), 32'(busy), 32'(i < 10));
        end
        check("term_tick_count", 32'(tick_count), 2);

        // Reset mid-run at cnt=4.
        burst_len = 4'd3;
        req = 3'b000; step(1);
        req = 3'b100; step(1);
        check("mr_busy", 32'(busy), 1);
        step(4);
        rst_n = 1'b0; step(1);
        check("mr_busy0", 32'(busy), 0);
        check("mr_tick0", 32'(tick), 0);
        check("mr_phase0", 32'(phase), 0);
        check("mr_req_seen0", 32'(req_seen), 0);
        check("mr_tick_count0", 32'(tick_count), 0);
        rst_n = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step(1);
            check($sformatf("mr_idle_tick_%0d", i), 32'(tick), 0);
            check($sformatf("mr_idle_busy_%0d", i), 32'(busy), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
